mux2x1_rr_arbiter: RTL and testbench

Round-robin arbiter and buffering front-end for the 2:1 8-bit lane mux.
- Two upstream byte streams (lane 0, lane 1) are each buffered in a small FIFO.
- The arbiter drains them alternately into one registered output stream with a valid/ready handshake.
- Sits between the lane sources and the downstream serializer, and drives the mux select that the 2:1 datapath consumes.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/mux2x1_rr_arbiter.sv | 87 ++++++++
 tb/tb_mux2x1_rr_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants for the 2:1 lane-mux arbiter front-end.
// Optional build macro: ARB_STRICT_PRIO_EN (lane 0 wins ties instead of round-robin).
package mux_arb_pkg;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_AF_LEVEL = 3;
   localparam int DEF_PTR_W    = $clog2(DEF_DEPTH);
   localparam int DEF_CNT_W    = DEF_PTR_W + 1;
   localparam int LANE0        = 0;
   localparam int LANE1        = 1;
   localparam int NUM_LANES    = 2;
endpackage

// File: rtl/sync_fifo.sv
// Per-lane synchronous FIFO: full pushes are dropped and flagged with a one-cycle ovf pulse.
module sync_fifo
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEF_AF_LEVEL,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              almost_full,
   output logic              ovf
);
   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [PW-1:0]                rd_ptr, wr_ptr;
   logic                         full, empty, do_push, do_pop;
   logic [CW-1:0]                cnt_nxt;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Full check uses the pre-edge count, so a same-cycle pop never frees room for the push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign ovf     = push && full;
   assign cnt_nxt = count + CW'(do_push) - CW'(do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count       <= cnt_nxt;
         almost_full <= (cnt_nxt >= CW'(AF_LEVEL));
      end
   end
endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Two buffered byte lanes arbitrated into one registered valid/ready stream.
// Optional build macro: ARB_STRICT_PRIO_EN (lane 0 wins when both lanes hold data).
module mux2x1_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEF_AF_LEVEL
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] in0,
   input  logic              valid0,
   input  logic [DATA_W-1:0] in1,
   input  logic              valid1,
   input  logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              sel,
   output logic              almost_full0,
   output logic              almost_full1,
   output logic              overflow
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;
   logic [NUM_LANES-1:0][CW-1:0]     cnt;
   logic [NUM_LANES-1:0]             vin, pop, ne, af, ovf;
   logic                             load, grant, last_grant;

   assign din = {in1, in0};
   assign vin = {valid1, valid0};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign ne[i]  = (cnt[i] != '0);
      assign pop[i] = load && (grant == 1'(i));
      sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
         .clk         (clk),
         .reset_L     (reset_L),
         .push        (vin[i]),
         .din         (din[i]),
         .pop         (pop[i]),
         .dout        (dout[i]),
         .count       (cnt[i]),
         .almost_full (af[i]),
         .ovf         (ovf[i])
      );
   end

   assign load         = (!valid_out || ready_out) && (|ne);
   assign almost_full0 = af[LANE0];
   assign almost_full1 = af[LANE1];

   always_comb begin
      grant = 1'(LANE0);
      if (ne[LANE0] && ne[LANE1]) begin
`ifdef ARB_STRICT_PRIO_EN
         grant = 1'(LANE0);
`else
         grant = ~last_grant;
`endif
      end else if (ne[LANE1]) begin
         grant = 1'(LANE1);
      end
   end

   // last_grant resets to lane 1 so the first contested grant goes to lane 0.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         overflow <= overflow | (|ovf);
         if (load) begin
            data_out   <= dout[grant];
            valid_out  <= 1'b1;
            sel        <= grant;
            last_grant <= grant;
         end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Randomized bench for mux2x1_rr_arbiter against a queue-based reference model.
// Optional build macro: ARB_STRICT_PRIO_EN (model follows the strict-priority rule).
module tb_mux2x1_rr_arbiter;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int AFL = 3;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic [DW-1:0] in0 = '0, in1 = '0;
   logic          valid0 = 1'b0, valid1 = 1'b0, ready_out = 1'b0;
   logic [DW-1:0] data_out;
   logic          valid_out, sel, almost_full0, almost_full1, overflow;

   mux2x1_rr_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
      .clk(clk), .reset_L(reset_L),
      .in0(in0), .valid0(valid0), .in1(in1), .valid1(valid1),
      .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .sel(sel),
      .almost_full0(almost_full0), .almost_full1(almost_full1), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: lane queues plus the visible output word.
   logic [DW-1:0] q0[$], q1[$];
   logic [DW-1:0] m_data;
   logic          m_vld, m_sel, m_last, m_ovf, m_af0, m_af1;

   task automatic model_reset();
      q0.delete(); q1.delete();
      m_data = '0; m_vld = 0; m_sel = 0; m_last = 1; m_ovf = 0; m_af0 = 0; m_af1 = 0;
   endtask

   task automatic model_edge();
      bit have0, have1, take, g, acc0, acc1;
      have0 = (q0.size() != 0);
      have1 = (q1.size() != 0);
      acc0  = valid0 && (q0.size() < DEPTH);
      acc1  = valid1 && (q1.size() < DEPTH);
      if ((valid0 && !acc0) || (valid1 && !acc1)) m_ovf = 1;
      take = (!m_vld || ready_out) && (have0 || have1);
      if (have0 && have1) begin
`ifdef ARB_STRICT_PRIO_EN
         g = 0;
`else
         g = !m_last;
`endif
      end else g = have1;
      if (take) begin
         m_data = g ? q1.pop_front() : q0.pop_front();
         m_vld = 1; m_sel = g; m_last = g;
      end else if (m_vld && ready_out) m_vld = 0;
      if (acc0) q0.push_back(in0);
      if (acc1) q1.push_back(in1);
      m_af0 = (q0.size() >= AFL);
      m_af1 = (q1.size() >= AFL);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid_out"}, 32'(valid_out), 32'(m_vld));
      check({tag, ".data_out"}, 32'(data_out), 32'(m_data));
      check({tag, ".sel"}, 32'(sel), 32'(m_sel));
      check({tag, ".af0"}, 32'(almost_full0), 32'(m_af0));
      check({tag, ".af1"}, 32'(almost_full1), 32'(m_af1));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // Called one time unit after a rising edge; leaves us one unit after the next.
   task automatic step(input string tag, input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic rdy);
      valid0 = v0; in0 = d0; valid1 = v1; in1 = d1; ready_out = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      model_reset();
      #3;
      check_outputs("reset");
      @(negedge clk); reset_L = 1'b1;
      @(posedge clk); model_edge(); #1;

      for (int i = 0; i < 10; i++) step("idle", 0, 8'h00, 0, 8'h00, 1);

      step("lane0", 1, 8'h11, 0, 8'h00, 1);
      step("lane0", 1, 8'h22, 0, 8'h00, 1);
      check("lane0.first", 32'(data_out), 32'h11);
      step("lane0", 1, 8'h33, 0, 8'h00, 1);
      for (int i = 0; i < 3; i++) step("lane0", 0, 8'h00, 0, 8'h00, 1);

      // Load both lanes while the output stalls, then release.
      step("both", 1, 8'hA0, 1, 8'hB0, 0);
      step("both", 1, 8'hA1, 1, 8'hB1, 0);
      step("both", 0, 8'h00, 0, 8'h00, 1);
      step("both", 0, 8'h00, 0, 8'h00, 1);
      step("both", 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < 3; i++) step("both", 0, 8'h00, 0, 8'h00, 1);

      step("bp", 1, 8'h51, 1, 8'h61, 1);
      step("bp", 1, 8'h52, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) step("bp", 0, 8'h00, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) step("bp", 0, 8'h00, 0, 8'h00, 1);

      for (int i = 0; i < 6; i++) step("ovf", 0, 8'h00, 1, 8'(8'hC0 + i), 0);
      check("ovf.sticky_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) step("ovf", 0, 8'h00, 0, 8'h00, 1);
      check("ovf.sticky_hold", 32'(overflow), 32'd1);

      // Mid-operation reset with data buffered and an output word pending.
      step("mrst", 1, 8'hD0, 1, 8'hE0, 0);
      step("mrst", 1, 8'hD1, 1, 8'hE1, 0);
      valid0 = 0; valid1 = 0;
      reset_L = 1'b0;
      model_reset();
      #1;
      check_outputs("mrst.async");
      @(negedge clk); reset_L = 1'b1;
      @(posedge clk); model_edge(); #1;
      step("mrst", 0, 8'h00, 1, 8'h77, 1);
      step("mrst", 0, 8'h00, 0, 8'h00, 1);
      check("mrst.first", 32'(data_out), 32'h77);
      check("mrst.sel", 32'(sel), 32'd1);

      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 99) < 45), 8'($urandom),
              ($urandom_range(0, 99) < 45), 8'($urandom),
              ($urandom_range(0, 99) < 60));
      end
      for (int i = 0; i < 12; i++) step("flush", 0, 8'h00, 0, 8'h00, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
